// File: rtl/cluster_chunk_sched.sv
// Chunk scheduler for Compute_Cluster: ping-pong IFM/filter bank control, chunk start pulses,
// output-buffer walk and IFM channel-stacking shift. Optional macro SCHED_STALL_CNT_EN adds stall_cnt_o.
module cluster_chunk_sched #(
    parameter int unsigned MEM_SIZE        = 128,
    parameter int unsigned PREFIX_SUM_SIZE = 32,
    parameter int unsigned CHANNEL_NUM     = 16,
    parameter int unsigned OUTPUT_BUF_NUM  = 4,
    parameter int unsigned IFM_SHIFT_NUM   = 8,
    parameter int unsigned GROUP_NUM       = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic ifm_load_done_i,
    input  logic filter_load_done_i,
    input  logic total_chunk_end_i,
    output logic ifm_load_req_o,
    output logic filter_load_req_o,
    output logic ifm_wr_sel_o,
    output logic ifm_rd_sel_o,
    output logic filter_wr_sel_o,
    output logic filter_rd_sel_o,
    output logic run_valid_o,
    output logic total_chunk_start_o,
    output logic [((OUTPUT_BUF_NUM > 1) ? $clog2(OUTPUT_BUF_NUM) : 1)-1:0] acc_buf_sel_o,
    output logic [((OUTPUT_BUF_NUM > 1) ? $clog2(OUTPUT_BUF_NUM) : 1)-1:0] out_buf_sel_o,
    output logic [$clog2(PREFIX_SUM_SIZE)-1:0] shift_left_o,
    output logic [$clog2((MEM_SIZE + PREFIX_SUM_SIZE - 1) / PREFIX_SUM_SIZE):0] rd_sparsemap_step_o,
    output logic [$clog2((MEM_SIZE + PREFIX_SUM_SIZE - 1) / PREFIX_SUM_SIZE):0] rd_sparsemap_last_o,
    output logic group_done_o,
    output logic busy_o,
`ifdef SCHED_STALL_CNT_EN
    output logic [31:0] stall_cnt_o,
`endif
    output logic done_o
);

    localparam int unsigned OUT_NUM = (IFM_SHIFT_NUM < OUTPUT_BUF_NUM) ? IFM_SHIFT_NUM : OUTPUT_BUF_NUM;
    localparam int unsigned RD_NUM  = (MEM_SIZE + PREFIX_SUM_SIZE - 1) / PREFIX_SUM_SIZE;
    localparam int unsigned SW      = (OUTPUT_BUF_NUM > 1) ? $clog2(OUTPUT_BUF_NUM) : 1;
    localparam int unsigned SLW     = $clog2(PREFIX_SUM_SIZE);
    localparam int unsigned STW     = $clog2(RD_NUM) + 1;
    localparam int unsigned SHW     = (IFM_SHIFT_NUM > 1) ? $clog2(IFM_SHIFT_NUM) : 1;
    localparam int unsigned RFW     = (GROUP_NUM > 1) ? $clog2(GROUP_NUM) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRELOAD,
        S_RUN,
        S_WAIT_LOAD,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [SHW-1:0]   shift_q, shift_d;
    logic [SW-1:0]    buf_q, buf_d;
    logic [RFW-1:0]   ref_q, ref_d;
    logic             ifm_full_q, ifm_full_d;
    logic             flt_full_q, flt_full_d;
    logic             ifm_wr_q, ifm_wr_d;
    logic             ifm_rd_q, ifm_rd_d;
    logic             flt_wr_q, flt_wr_d;
    logic             flt_rd_q, flt_rd_d;
    logic             ifm_req_q, ifm_req_d;
    logic             flt_req_q, flt_req_d;
    logic             run_valid_q, run_valid_d;
    logic             chunk_start_q, chunk_start_d;
    logic             group_done_q, group_done_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [SLW-1:0]   shift_left_q, shift_left_d;
    logic [STW-1:0]   step_q, step_d;
    logic [STW-1:0]   last_q, last_d;

    logic             ifm_full_c, flt_full_c, both_full_c;
    logic             end_c, grp_last_c, ref_last_c, swap_c, start_acc_c, hold_req_c;
    logic [31:0]      shift_prod_c;

`ifdef SCHED_STALL_CNT_EN
    logic [31:0]      stall_q, stall_d;
`endif

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        buf_d        = buf_q;
        ref_d        = ref_q;
        ifm_wr_d     = ifm_wr_q;
        flt_wr_d     = flt_wr_q;
        swap_c       = 1'b0;
        group_done_d = 1'b0;

        // A load-done pulse arriving with the swap check already counts as a full bank
        ifm_full_c   = ifm_full_q | ifm_load_done_i;
        flt_full_c   = flt_full_q | filter_load_done_i;
        both_full_c  = ifm_full_c & flt_full_c;
        end_c        = (state_q == S_RUN) & total_chunk_end_i;
        grp_last_c   = (buf_q == SW'(OUT_NUM - 1));
        ref_last_c   = (ref_q == RFW'(GROUP_NUM - 1));
        start_acc_c  = start_i & ((state_q == S_IDLE) | (state_q == S_DONE));

        case (state_q)
            S_IDLE: begin
                shift_d  = '0;
                buf_d    = '0;
                ref_d    = '0;
                ifm_wr_d = 1'b0;
                flt_wr_d = 1'b0;
                if (start_i) begin
                    state_d = S_PRELOAD;
                end
            end
            S_PRELOAD: begin
                if (both_full_c) begin
                    swap_c  = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (end_c) begin
                    shift_d = (shift_q == SHW'(IFM_SHIFT_NUM - 1)) ? '0 : shift_q + SHW'(1);
                    buf_d   = grp_last_c ? '0 : buf_q + SW'(1);
                    if (grp_last_c) begin
                        group_done_d = 1'b1;
                        if (ref_last_c) begin
                            state_d = S_DONE;
                        end else if (both_full_c) begin
                            swap_c = 1'b1;
                            ref_d  = ref_q + RFW'(1);
                        end else begin
                            state_d = S_WAIT_LOAD;
                        end
                    end
                end
            end
            S_WAIT_LOAD: begin
                if (both_full_c) begin
                    swap_c  = 1'b1;
                    ref_d   = ref_q + RFW'(1);
                    state_d = S_RUN;
                end
            end
            S_DONE: begin
                if (start_i) begin
                    shift_d = '0;
                    buf_d   = '0;
                    ref_d   = '0;
                    state_d = S_PRELOAD;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (swap_c) begin
            ifm_wr_d = ~ifm_wr_q;
            flt_wr_d = ~flt_wr_q;
        end
        ifm_rd_d   = ~ifm_wr_d;
        flt_rd_d   = ~flt_wr_d;
        ifm_full_d = swap_c ? 1'b0 : ifm_full_c;
        flt_full_d = swap_c ? 1'b0 : flt_full_c;

        busy_d        = (state_d == S_PRELOAD) | (state_d == S_RUN) | (state_d == S_WAIT_LOAD);
        done_d        = (state_d == S_DONE);
        run_valid_d   = (state_d == S_RUN);
        chunk_start_d = (state_d == S_RUN) & ((state_q != S_RUN) | end_c);

        // The last group's banks are already loaded; no further refill is requested
        hold_req_c = (ref_d == RFW'(GROUP_NUM - 1)) & (state_d != S_PRELOAD);
        ifm_req_d  = ~ifm_full_d & busy_d & ~hold_req_c;
        flt_req_d  = ~flt_full_d & busy_d & ~hold_req_c;

        shift_prod_c = 32'(shift_d) * 32'(CHANNEL_NUM);
        shift_left_d = SLW'(shift_prod_c % 32'(PREFIX_SUM_SIZE));
        step_d       = STW'(shift_prod_c / 32'(PREFIX_SUM_SIZE));
        last_d       = STW'(RD_NUM - 1) + step_d;

`ifdef SCHED_STALL_CNT_EN
        stall_d = stall_q;
        if ((state_q == S_WAIT_LOAD) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_d = stall_q + 32'd1;
        end
        if (start_acc_c) begin
            stall_d = '0;
        end
`endif
    end

    // State, counters and registered outputs
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= S_IDLE;
            shift_q       <= '0;
            buf_q         <= '0;
            ref_q         <= '0;
            ifm_full_q    <= 1'b0;
            flt_full_q    <= 1'b0;
            ifm_wr_q      <= 1'b0;
            ifm_rd_q      <= 1'b1;
            flt_wr_q      <= 1'b0;
            flt_rd_q      <= 1'b1;
            ifm_req_q     <= 1'b0;
            flt_req_q     <= 1'b0;
            run_valid_q   <= 1'b0;
            chunk_start_q <= 1'b0;
            group_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            shift_left_q  <= '0;
            step_q        <= '0;
            last_q        <= STW'(RD_NUM - 1);
`ifdef SCHED_STALL_CNT_EN
            stall_q       <= '0;
`endif
        end else begin
            state_q       <= state_d;
            shift_q       <= shift_d;
            buf_q         <= buf_d;
            ref_q         <= ref_d;
            ifm_full_q    <= ifm_full_d;
            flt_full_q    <= flt_full_d;
            ifm_wr_q      <= ifm_wr_d;
            ifm_rd_q      <= ifm_rd_d;
            flt_wr_q      <= flt_wr_d;
            flt_rd_q      <= flt_rd_d;
            ifm_req_q     <= ifm_req_d;
            flt_req_q     <= flt_req_d;
            run_valid_q   <= run_valid_d;
            chunk_start_q <= chunk_start_d;
            group_done_q  <= group_done_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            shift_left_q  <= shift_left_d;
            step_q        <= step_d;
            last_q        <= last_d;
`ifdef SCHED_STALL_CNT_EN
            stall_q       <= stall_d;
`endif
        end
    end

    assign ifm_load_req_o      = ifm_req_q;
    assign filter_load_req_o   = flt_req_q;
    assign ifm_wr_sel_o        = ifm_wr_q;
    assign ifm_rd_sel_o        = ifm_rd_q;
    assign filter_wr_sel_o     = flt_wr_q;
    assign filter_rd_sel_o     = flt_rd_q;
    assign run_valid_o         = run_valid_q;
    assign total_chunk_start_o = chunk_start_q;
    assign acc_buf_sel_o       = buf_q;
    assign out_buf_sel_o       = buf_q;
    assign shift_left_o        = shift_left_q;
    assign rd_sparsemap_step_o = step_q;
    assign rd_sparsemap_last_o = last_q;
    assign group_done_o        = group_done_q;
    assign busy_o              = busy_q;
    assign done_o              = done_q;
`ifdef SCHED_STALL_CNT_EN
    assign stall_cnt_o         = stall_q;
`endif

endmodule

// File: tb/tb_cluster_chunk_sched.sv
// Directed bench for cluster_chunk_sched with default parameters.
module tb_cluster_chunk_sched;

    logic       clk_i;
    logic       rst_ni;
    logic       start_i;
    logic       ifm_load_done_i;
    logic       filter_load_done_i;
    logic       total_chunk_end_i;
    logic       ifm_load_req_o;
    logic       filter_load_req_o;
    logic       ifm_wr_sel_o;
    logic       ifm_rd_sel_o;
    logic       filter_wr_sel_o;
    logic       filter_rd_sel_o;
    logic       run_valid_o;
    logic       total_chunk_start_o;
    logic [1:0] acc_buf_sel_o;
    logic [1:0] out_buf_sel_o;
    logic [4:0] shift_left_o;
    logic [2:0] rd_sparsemap_step_o;
    logic [2:0] rd_sparsemap_last_o;
    logic       group_done_o;
    logic       busy_o;
    logic       done_o;
`ifdef SCHED_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int checks;
    int errors;

    cluster_chunk_sched dut (
        .clk_i               (clk_i),
        .rst_ni              (rst_ni),
        .start_i             (start_i),
        .ifm_load_done_i     (ifm_load_done_i),
        .filter_load_done_i  (filter_load_done_i),
        .total_chunk_end_i   (total_chunk_end_i),
        .ifm_load_req_o      (ifm_load_req_o),
        .filter_load_req_o   (filter_load_req_o),
        .ifm_wr_sel_o        (ifm_wr_sel_o),
        .ifm_rd_sel_o        (ifm_rd_sel_o),
        .filter_wr_sel_o     (filter_wr_sel_o),
        .filter_rd_sel_o     (filter_rd_sel_o),
        .run_valid_o         (run_valid_o),
        .total_chunk_start_o (total_chunk_start_o),
        .acc_buf_sel_o       (acc_buf_sel_o),
        .out_buf_sel_o       (out_buf_sel_o),
        .shift_left_o        (shift_left_o),
        .rd_sparsemap_step_o (rd_sparsemap_step_o),
        .rd_sparsemap_last_o (rd_sparsemap_last_o),
        .group_done_o        (group_done_o),
        .busy_o              (busy_o),
`ifdef SCHED_STALL_CNT_EN
        .stall_cnt_o         (stall_cnt_o),
`endif
        .done_o              (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_walk(input string tag, input int b, input int sl, input int st, input int la);
        chk({tag, "_acc"},   32'(acc_buf_sel_o),       32'(b));
        chk({tag, "_out"},   32'(out_buf_sel_o),       32'(b));
        chk({tag, "_shl"},   32'(shift_left_o),        32'(sl));
        chk({tag, "_step"},  32'(rd_sparsemap_step_o), 32'(st));
        chk({tag, "_last"},  32'(rd_sparsemap_last_o), 32'(la));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_ifm_rd"},  32'(ifm_rd_sel_o),        32'd1);
        chk({tag, "_flt_rd"},  32'(filter_rd_sel_o),     32'd1);
        chk({tag, "_ifm_wr"},  32'(ifm_wr_sel_o),        32'd0);
        chk({tag, "_flt_wr"},  32'(filter_wr_sel_o),     32'd0);
        chk({tag, "_rv"},      32'(run_valid_o),         32'd0);
        chk({tag, "_start"},   32'(total_chunk_start_o), 32'd0);
        chk({tag, "_busy"},    32'(busy_o),              32'd0);
        chk({tag, "_done"},    32'(done_o),              32'd0);
        chk({tag, "_ireq"},    32'(ifm_load_req_o),      32'd0);
        chk({tag, "_freq"},    32'(filter_load_req_o),   32'd0);
        chk({tag, "_gdone"},   32'(group_done_o),        32'd0);
        chk_walk(tag, 0, 0, 0, 3);
    endtask

    task automatic chunk_end();
        total_chunk_end_i = 1'b1;
        tick();
        total_chunk_end_i = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_ni = 1'b0;
        start_i = 1'b0;
        ifm_load_done_i = 1'b0;
        filter_load_done_i = 1'b0;
        total_chunk_end_i = 1'b0;

        repeat (2) tick();
        chk_reset("rst");
        rst_ni = 1'b1;
        tick();

        // Start and preload both banks
        start_i = 1'b1; tick(); start_i = 1'b0;
        chk("pre_busy", 32'(busy_o), 32'd1);
        chk("pre_ireq", 32'(ifm_load_req_o), 32'd1);
        chk("pre_freq", 32'(filter_load_req_o), 32'd1);
        chk("pre_rv",   32'(run_valid_o), 32'd0);
        tick();
        ifm_load_done_i = 1'b1; tick(); ifm_load_done_i = 1'b0;
        chk("pre_ireq_full", 32'(ifm_load_req_o), 32'd0);
        chk("pre_freq_open", 32'(filter_load_req_o), 32'd1);
        chk("pre_hold_rv",   32'(run_valid_o), 32'd0);
        tick();
        filter_load_done_i = 1'b1; tick(); filter_load_done_i = 1'b0;
        chk("run_ifm_wr", 32'(ifm_wr_sel_o), 32'd1);
        chk("run_ifm_rd", 32'(ifm_rd_sel_o), 32'd0);
        chk("run_flt_wr", 32'(filter_wr_sel_o), 32'd1);
        chk("run_flt_rd", 32'(filter_rd_sel_o), 32'd0);
        chk("run_rv",     32'(run_valid_o), 32'd1);
        chk("run_start",  32'(total_chunk_start_o), 32'd1);
        chk("run_ireq",   32'(ifm_load_req_o), 32'd1);
        chk("run_freq",   32'(filter_load_req_o), 32'd1);
        chk_walk("g1e0", 0, 0, 0, 3);
        tick();
        chk("run_start_pulse", 32'(total_chunk_start_o), 32'd0);
        chk("run_rv_hold",     32'(run_valid_o), 32'd1);

        // Group 1: only the IFM bank is refilled, so the group end stalls
        ifm_load_done_i = 1'b1; tick(); ifm_load_done_i = 1'b0;
        chk("g1_ireq", 32'(ifm_load_req_o), 32'd0);
        chunk_end();
        chk_walk("g1e1", 1, 16, 0, 3);
        chk("g1e1_start", 32'(total_chunk_start_o), 32'd1);
        chk("g1e1_gdone", 32'(group_done_o), 32'd0);
        tick();
        chk("g1_start_low", 32'(total_chunk_start_o), 32'd0);
        start_i = 1'b1; tick(); start_i = 1'b0;
        chk("busy_start_rv",    32'(run_valid_o), 32'd1);
        chk("busy_start_pulse", 32'(total_chunk_start_o), 32'd0);
        chk_walk("busy_start", 1, 16, 0, 3);
        chunk_end();
        chk_walk("g1e2", 2, 0, 1, 4);
        chunk_end();
        chk_walk("g1e3", 3, 16, 1, 4);
        chunk_end();
        chk_walk("g1e4", 0, 0, 2, 5);
        chk("g1e4_gdone", 32'(group_done_o), 32'd1);
        chk("wait_rv",    32'(run_valid_o), 32'd0);
        chk("wait_start", 32'(total_chunk_start_o), 32'd0);
        chk("wait_busy",  32'(busy_o), 32'd1);
        chk("wait_ireq",  32'(ifm_load_req_o), 32'd0);
        chk("wait_freq",  32'(filter_load_req_o), 32'd1);
        chunk_end();
        chk_walk("wait_end_ign", 0, 0, 2, 5);
        chk("wait_gdone_low", 32'(group_done_o), 32'd0);
        repeat (5) tick();
        chk("wait_rv_still", 32'(run_valid_o), 32'd0);
        filter_load_done_i = 1'b1; tick(); filter_load_done_i = 1'b0;
        chk("g2_rv",     32'(run_valid_o), 32'd1);
        chk("g2_start",  32'(total_chunk_start_o), 32'd1);
        chk("g2_ifm_wr", 32'(ifm_wr_sel_o), 32'd0);
        chk("g2_ifm_rd", 32'(ifm_rd_sel_o), 32'd1);
        chk("g2_flt_wr", 32'(filter_wr_sel_o), 32'd0);
        chk("g2_ireq",   32'(ifm_load_req_o), 32'd1);
        chk("g2_freq",   32'(filter_load_req_o), 32'd1);
`ifdef SCHED_STALL_CNT_EN
        chk("stall_cnt", stall_cnt_o, 32'd7);
`endif

        // Group 2: filter load lands on the group-end cycle, no stall
        ifm_load_done_i = 1'b1; tick(); ifm_load_done_i = 1'b0;
        chunk_end();
        chk_walk("g2e1", 1, 16, 2, 5);
        chunk_end();
        chk_walk("g2e2", 2, 0, 3, 6);
        chunk_end();
        chk_walk("g2e3", 3, 16, 3, 6);
        filter_load_done_i = 1'b1;
        total_chunk_end_i = 1'b1;
        tick();
        filter_load_done_i = 1'b0;
        total_chunk_end_i = 1'b0;
        chk_walk("g2e4", 0, 0, 0, 3);
        chk("g2e4_gdone",  32'(group_done_o), 32'd1);
        chk("g2e4_rv",     32'(run_valid_o), 32'd1);
        chk("g2e4_start",  32'(total_chunk_start_o), 32'd1);
        chk("g2e4_ifm_wr", 32'(ifm_wr_sel_o), 32'd1);
        chk("g2e4_flt_rd", 32'(filter_rd_sel_o), 32'd0);

        // Group 3: both banks loaded early; entering the last group stops requests
        ifm_load_done_i = 1'b1;
        filter_load_done_i = 1'b1;
        tick();
        ifm_load_done_i = 1'b0;
        filter_load_done_i = 1'b0;
        repeat (4) chunk_end();
        chk_walk("g3e4", 0, 0, 2, 5);
        chk("g3e4_ifm_wr", 32'(ifm_wr_sel_o), 32'd0);
        chk("g3e4_start",  32'(total_chunk_start_o), 32'd1);
        chk("g3e4_rv",     32'(run_valid_o), 32'd1);
        chk("last_ireq",   32'(ifm_load_req_o), 32'd0);
        chk("last_freq",   32'(filter_load_req_o), 32'd0);

        // Group 4 ends the run
        repeat (4) chunk_end();
        chk_walk("g4e4", 0, 0, 0, 3);
        chk("done_done",  32'(done_o), 32'd1);
        chk("done_busy",  32'(busy_o), 32'd0);
        chk("done_rv",    32'(run_valid_o), 32'd0);
        chk("done_gdone", 32'(group_done_o), 32'd1);
        chk("done_start", 32'(total_chunk_start_o), 32'd0);
        chk("done_ireq",  32'(ifm_load_req_o), 32'd0);
        chk("done_freq",  32'(filter_load_req_o), 32'd0);
        chunk_end();
        chk_walk("done_end_ign", 0, 0, 0, 3);
        chk("done_hold",     32'(done_o), 32'd1);
        chk("done_gdone_lo", 32'(group_done_o), 32'd0);

        // Restart, run two chunks, then reset asynchronously mid-chunk
        start_i = 1'b1; tick(); start_i = 1'b0;
        chk("re_done", 32'(done_o), 32'd0);
        chk("re_busy", 32'(busy_o), 32'd1);
        chk("re_ireq", 32'(ifm_load_req_o), 32'd1);
        chk("re_freq", 32'(filter_load_req_o), 32'd1);
        chk("re_rv",   32'(run_valid_o), 32'd0);
        ifm_load_done_i = 1'b1;
        filter_load_done_i = 1'b1;
        tick();
        ifm_load_done_i = 1'b0;
        filter_load_done_i = 1'b0;
        chk("re_run_rv",    32'(run_valid_o), 32'd1);
        chk("re_run_start", 32'(total_chunk_start_o), 32'd1);
        chk("re_ifm_wr",    32'(ifm_wr_sel_o), 32'd1);
        chunk_end();
        chunk_end();
        chk_walk("re_e2", 2, 0, 1, 4);
        #3;
        rst_ni = 1'b0;
        #1;
        chk_reset("arst");
        tick();
        rst_ni = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cluster_chunk_sched.md
Name: cluster_chunk_sched

Overview:
- Hardware chunk scheduler for Compute_Cluster.
- Sequences ping-pong IFM and filter buffer banks, run_valid and total_chunk_start.
- Walks accumulate/output buffer selection and channel-stacking IFM shift (shift_left, rd_sparsemap_step/last).
- Handshakes with the host loader so banks are refilled while the other bank is being read.

Parameters:
- MEM_SIZE, 128, elements per buffer bank
- PREFIX_SUM_SIZE, 32, elements per sparsemap read word
- CHANNEL_NUM, 16, channels per IFM position (shift granularity)
- OUTPUT_BUF_NUM, 4, accumulate/output buffers per compute unit
- IFM_SHIFT_NUM, 8, shift positions before the shift counter wraps
- GROUP_NUM, 4, filter groups (bank swaps) per run; last group ends in DONE
- Localparams:
  - OUT_NUM = min(IFM_SHIFT_NUM, OUTPUT_BUF_NUM)
  - RD_NUM = ceil(MEM_SIZE/PREFIX_SUM_SIZE)
  - SW = max(1, clog2(OUTPUT_BUF_NUM))

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- start_i  in  1  pulse: begin a run (honoured only in IDLE/DONE)
- ifm_load_done_i  in  1  pulse: host finished writing IFM write bank
- filter_load_done_i  in  1  pulse: host finished writing filter write bank
- total_chunk_end_i  in  1  from cluster: current chunk finished
- ifm_load_req_o  out  1  level: IFM write bank needs filling
- filter_load_req_o  out  1  level: filter write bank needs filling
- ifm_wr_sel_o / ifm_rd_sel_o  out  1  IFM bank selects (always complementary)
- filter_wr_sel_o / filter_rd_sel_o  out  1  filter bank selects (always complementary)
- run_valid_o  out  1  cluster run enable
- total_chunk_start_o  out  1  one-cycle chunk start pulse
- acc_buf_sel_o / out_buf_sel_o  out  SW  buffer select (equal)
- shift_left_o  out  clog2(PREFIX_SUM_SIZE)  (shift*CHANNEL_NUM) % PREFIX_SUM_SIZE
- rd_sparsemap_step_o  out  clog2(RD_NUM)+1  (shift*CHANNEL_NUM) / PREFIX_SUM_SIZE
- rd_sparsemap_last_o  out  clog2(RD_NUM)+1  RD_NUM-1+step
- group_done_o  out  1  pulse: output buffer group complete
- busy_o  out  1  state is PRELOAD/RUN/WAIT_LOAD
- done_o  out  1  level: run complete

Behaviour:
- Reset values: all outputs 0, except ifm_rd_sel_o = filter_rd_sel_o = 1 and rd_sparsemap_last_o = RD_NUM-1. State IDLE; counters 0; bank-full flags 0.
- All outputs are registered.
- Bank-full flags:
  - ifm_full is set by ifm_load_done_i and cleared on a bank swap; filter_full behaves the same with filter_load_done_i.
  - A done pulse in the same cycle as a swap check counts as set.
- load_req_o = !full && busy && !(ref_cnt == GROUP_NUM-1 && state != PRELOAD).
- Swap: toggles both wr_sel and rd_sel of IFM and filter, and clears both flags.
- IDLE:
  - start_i -> PRELOAD.
  - Counters zeroed; wr_sel = 0.
- PRELOAD:
  - When both flags are set -> swap, then RUN.
  - Next cycle: run_valid_o = 1 and total_chunk_start_o pulses.
- RUN:
  - run_valid_o = 1.
  - On total_chunk_end_i:
    - shift_cnt advances, wrapping IFM_SHIFT_NUM-1 -> 0.
    - buf_cnt advances, wrapping OUT_NUM-1 -> 0.
    - shift-derived outputs update on the same edge.
  - Non-group end: total_chunk_start_o pulses the following cycle.
  - Group end (buf_cnt was OUT_NUM-1): group_done_o pulses.
    - If ref_cnt == GROUP_NUM-1 -> DONE.
    - Else if both flags are set -> swap, ref_cnt++, stay in RUN, start pulse next cycle.
    - Else -> WAIT_LOAD with run_valid_o = 0 from the next cycle.
- WAIT_LOAD:
  - run_valid_o = 0.
  - When both flags are set -> swap, ref_cnt++, RUN, start pulse on RUN entry.
  - total_chunk_end_i is ignored.
- DONE:
  - run_valid_o = 0; done_o = 1.
  - start_i -> PRELOAD, clearing done_o and counters.
- Boundary conditions:
  - total_chunk_end_i outside RUN is ignored.
  - start_i while busy is ignored.
  - rst_ni low mid-operation forces reset values immediately (asynchronous), even mid-chunk.
  - IFM_SHIFT_NUM = 1 keeps shift outputs at 0.
  - OUT_NUM = 1 makes every chunk a group end.

Optional Feature:
- Macro: SCHED_STALL_CNT_EN.
- Defined:
  - Adds output stall_cnt_o [31:0], which counts WAIT_LOAD cycles and saturates at 0xFFFFFFFF.
  - Cleared on reset and on start_i accepted.
- Undefined: port and counter absent; all other behaviour unchanged.

Test Plan:
- Reset then start_i; both load_done pulses at cycles 3 and 5 -> PRELOAD exits at cycle 5, wr_sel = 1, rd_sel = 0, run_valid_o and total_chunk_start_o high at cycle 6.
- Defaults, 4 chunk ends -> buf_sel 0,1,2,3, wrapping to 0 on the 4th end.
  - shift_left 0,16,0,16; step 0,0,1,1; last 3,3,4,4.
  - group_done_o pulses once.
- Group end with filter_full clear -> WAIT_LOAD, run_valid_o 0.
  - filter_load_done_i 7 cycles later -> swap and run_valid_o 1.
  - With SCHED_STALL_CNT_EN, stall_cnt_o = 7.
- Load done in the same cycle as group end -> no WAIT_LOAD, swap that edge, start pulse next cycle.
- 4th group end (ref_cnt = 3) -> DONE, done_o 1, load_req_o 0, later total_chunk_end_i ignored; start_i restarts PRELOAD.
- rst_ni low mid-RUN at buf_sel = 2 -> all outputs at reset values same cycle, including rd_sel = 1 and last = 3.
